// File: rtl/seq_multiplier.sv
// Sequential 8x8 unsigned shift-and-add multiplier.
// Advances only on clk edges where clk_half is high; a start is a 0->1 edge of ld
// as seen on those enabled ticks. One partial product is added per enabled tick,
// and the 16-bit product is presented with mult_ok after the ninth enabled tick
// (the capture tick counts as the first).
module seq_multiplier (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_half,
  input  logic        ld,
  input  logic [7:0]  mult1,
  input  logic [7:0]  mult2,
  output logic [15:0] mult_res,
  output logic        mult_ok
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] acc;
  logic [2:0]  step;
  logic        ld_q;

  logic        start;
  logic [15:0] partial;
  logic [15:0] acc_next;

  // Start edge detection and the shifted partial product for the current step
  always_comb begin
    start    = ld & ~ld_q;
    partial  = 16'h0000;
    if (b[step]) begin
      partial = {8'h00, a} << step;
    end
    acc_next = acc + partial;
  end

  // Control FSM and datapath; everything holds on edges where clk_half is low
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      mult_ok  <= 1'b0;
      mult_res <= 16'h0000;
      ld_q     <= 1'b0;
      acc      <= 16'h0000;
      step     <= 3'd0;
      a        <= 8'h00;
      b        <= 8'h00;
    end else if (clk_half) begin
      ld_q <= ld;
      case (state)
        IDLE: begin
          mult_ok <= 1'b0;
          if (start) begin
            a     <= mult1;
            b     <= mult2;
            acc   <= 16'h0000;
            step  <= 3'd0;
            state <= BUSY;
          end
        end
        BUSY: begin
          acc  <= acc_next;
          step <= step + 3'd1;
          if (step == 3'd7) begin
            mult_res <= acc_next;
            mult_ok  <= 1'b1;
            state    <= DONE;
          end
        end
        DONE: begin
          mult_ok <= 1'b1;
          if (!ld) begin
            mult_ok <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          mult_ok <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 Port: clk, input, 1, system clock; reset, synchronous, active-low.
REQ-003 Port: reset, input, 1, synchronous active-low reset, sampled on every clk rising edge regardless of clk_half.
REQ-004 Port: clk_half, input, 1, phase enable; an "enabled tick" is a clk rising edge with clk_half==1.
REQ-005 Port: ld, input, 1, start request from the initiator; level held high until mult_ok is seen.
REQ-006 Port: mult1, input, 8, unsigned multiplicand.
REQ-007 Port: mult2, input, 8, unsigned multiplier.
REQ-008 Port: mult_res, output, 16, registered unsigned product mult1*mult2.
REQ-009 Port: mult_ok, output, 1, registered result-valid flag.

Function
REQ-010 State SHALL advance only on enabled ticks; on non-enabled edges all registers SHALL hold, except under reset.
REQ-011 States SHALL be IDLE, BUSY and DONE; an undefined encoding SHALL go to IDLE on the next enabled tick.
REQ-012 A registered copy ld_q SHALL be updated on every enabled tick; a start SHALL be the condition ld==1 && ld_q==0.
REQ-013 IDLE: mult_ok=0; on a start, capture a=mult1, b=mult2, clear the 16-bit accumulator and the 3-bit step counter, and go to BUSY; otherwise stay.
REQ-014 Operands SHALL be used only from the capture; later changes on mult1/mult2 SHALL NOT affect the result.
REQ-015 BUSY, step i = 0..7, one step per enabled tick: if b[i]==1, add (a << i) to the accumulator, 16-bit with no truncation; then increment i.
REQ-016 On step 7: mult_res <= final accumulator, mult_ok <= 1, next state DONE.
REQ-017 Latency: mult_ok SHALL be 1 after the 9th enabled tick, counting the capture tick as tick 1.
REQ-018 DONE: hold mult_ok=1 and mult_res; when ld==0, clear mult_ok and go to IDLE on that tick.
REQ-019 mult_res SHALL hold its last value until the next completion; it is not cleared on capture.
REQ-020 ld falling during BUSY SHALL be ignored; the computation completes, then DONE exits on the next enabled tick (mult_ok high for exactly 1 enabled tick).
REQ-021 ld held high continuously from a previous transaction into IDLE SHALL NOT start a new computation; a 0-to-1 transition is required.
REQ-022 A start seen in BUSY or DONE SHALL be ignored, not queued.
REQ-023 Phase contract: the initiator acts on clk_half==0 edges and this block on clk_half==1 edges, so mult_ok is low before the initiator's next action after it drops ld.
REQ-024 The product SHALL be exact for all 65536 operand pairs; maximum 0xFF*0xFF = 0xFE01.

Reset
REQ-025 On reset==0 at any clk edge: state=IDLE, mult_ok=0, mult_res=0x0000, ld_q=0, accumulator=0, counter=0, a=b=0.
REQ-026 Reset mid-BUSY or mid-DONE SHALL abort without producing a result; the first start after release SHALL be accepted normally.
REQ-027 Reset SHALL take precedence over a start in the same cycle.

Verification
REQ-028 Set mult1=0xFF, mult2=0xFF, raise ld -> mult_ok=1 after the 9th enabled tick; mult_res=0xFE01; drop ld -> mult_ok=0 on the next enabled tick.
REQ-029 mult1=0x80, mult2=0x02, then change the inputs to 0x01/0x01 after the capture tick -> mult_res=0x0100; also test 0x00*0xA5 -> 0x0000.
REQ-030 Keep ld high through DONE, drop it, then raise it again with new operands 0x12*0x34 -> exactly 1 result, 0x03A8; while ld stays high, no re-trigger.
REQ-031 Assert reset at BUSY step 4 of 0x0F*0x0F -> mult_ok=0 and mult_res=0x0000 immediately; the next transaction 0x03*0x05 gives 0x000F.
REQ-032 Hold clk_half=0 for 20 clks mid-BUSY -> state and counter frozen; the result is still correct (0x07*0x09 = 0x003F) after enable resumes.
REQ-033 Run a random 1000-pair loop through a clk_half-toggling initiator model -> every mult_res equals the reference product, with no missed or duplicated mult_ok.
